// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, datapath sizes, opcodes
// and default per-opcode decode masks.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int NREGS  = 16;
    localparam int SEL_W  = 4;
    localparam int IMM_W  = 19;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;
    localparam int C_MSB   = 18;
    localparam int C_LSB   = 0;

    typedef enum logic [4:0] {
        OP_ADD = 5'd0,
        OP_SUB = 5'd1,
        OP_AND = 5'd2,
        OP_OR  = 5'd3,
        OP_XOR = 5'd4,
        OP_SHL = 5'd5,
        OP_SHR = 5'd6,
        OP_LD  = 5'd7,
        OP_ST  = 5'd8,
        OP_BEQ = 5'd9,
        OP_NOP = 5'd31
    } opcode_e;

    // Bit i set means opcode i has that property; integrators override these.
    localparam logic [31:0] DEF_WRITES_RA_MASK = 32'h0;
    localparam logic [31:0] DEF_RA_SRC_MASK    = 32'h0;

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Busy bit per architectural register with set/clear/kill updates and three
// hazard queries that see through a same-cycle writeback.
module operand_fetch_scoreboard #(
    parameter int NREGS = 16,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_en,
    input  logic [SEL_W-1:0] set_sel,
    input  logic             clr_en,
    input  logic [SEL_W-1:0] clr_sel,
    input  logic             kill_en,
    input  logic [SEL_W-1:0] kill_sel,
    input  logic [SEL_W-1:0] q1_sel,
    input  logic [SEL_W-1:0] q2_sel,
    input  logic [SEL_W-1:0] qd_sel,
    output logic             q1_hz,
    output logic             q2_hz,
    output logic             qd_hz
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;

    // Clears are applied first so that a set to the same register wins.
    always_comb begin
        busy_next = busy;
        if (clr_en)
            busy_next[clr_sel] = 1'b0;
        if (kill_en)
            busy_next[kill_sel] = 1'b0;
        if (set_en)
            busy_next[set_sel] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            busy <= '0;
        else
            busy <= busy_next;
    end

    assign q1_hz = busy[q1_sel] && !(clr_en && (clr_sel == q1_sel));
    assign q2_hz = busy[q2_sel] && !(clr_en && (clr_sel == q2_sel));
    assign qd_hz = busy[qd_sel] && !(clr_en && (clr_sel == qd_sel));

endmodule

// File: rtl/operand_fetch.sv
// Issue stage: decodes register fields, reads/forwards operands, checks the
// busy scoreboard and registers one entry for the ALU behind valid/ready.
module operand_fetch #(
    parameter int          DATA_W         = cpu_pkg::DATA_W,
    parameter int          NREGS          = cpu_pkg::NREGS,
    parameter int          SEL_W          = cpu_pkg::SEL_W,
    parameter int          IMM_W          = cpu_pkg::IMM_W,
    parameter logic [31:0] WRITES_RA_MASK = cpu_pkg::DEF_WRITES_RA_MASK,
    parameter logic [31:0] RA_SRC_MASK    = cpu_pkg::DEF_RA_SRC_MASK
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic [SEL_W-1:0]  rf_sel1,
    output logic [SEL_W-1:0]  rf_sel2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic              wb_en,
    input  logic [SEL_W-1:0]  wb_sel,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_opcode,
    output logic [SEL_W-1:0]  out_dst,
    output logic              out_wr,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_imm
);
    import cpu_pkg::*;

    logic [4:0]        opcode;
    logic [SEL_W-1:0]  ra;
    logic [SEL_W-1:0]  rb;
    logic [SEL_W-1:0]  rc;
    logic [IMM_W-1:0]  c_field;
    logic              writes_ra;
    logic              ra_is_src;
    logic [SEL_W-1:0]  src1;
    logic [SEL_W-1:0]  src2;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;
    logic [DATA_W-1:0] imm_ext;
    logic              src1_hz;
    logic              src2_hz;
    logic              dst_busy_hz;
    logic              dst_hz;
    logic              accept;
    logic              kill_en;

    assign opcode    = in_instr[OPC_MSB:OPC_LSB];
    assign ra        = in_instr[RA_MSB:RA_LSB];
    assign rb        = in_instr[RB_MSB:RB_LSB];
    assign rc        = in_instr[RC_MSB:RC_LSB];
    assign c_field   = in_instr[IMM_W-1:0];
    assign writes_ra = WRITES_RA_MASK[opcode];
    assign ra_is_src = RA_SRC_MASK[opcode];

    assign src1    = rb;
    assign src2    = ra_is_src ? ra : rc;
    assign rf_sel1 = src1;
    assign rf_sel2 = src2;

    assign opnd_a  = (wb_en && (wb_sel == src1)) ? wb_data : rf_data1;
    assign opnd_b  = (wb_en && (wb_sel == src2)) ? wb_data : rf_data2;
    assign imm_ext = {{(DATA_W-IMM_W){c_field[IMM_W-1]}}, c_field};

    operand_fetch_scoreboard #(
        .NREGS (NREGS),
        .SEL_W (SEL_W)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .set_en   (accept && writes_ra),
        .set_sel  (ra),
        .clr_en   (wb_en),
        .clr_sel  (wb_sel),
        .kill_en  (kill_en),
        .kill_sel (out_dst),
        .q1_sel   (src1),
        .q2_sel   (src2),
        .qd_sel   (ra),
        .q1_hz    (src1_hz),
        .q2_hz    (src2_hz),
        .qd_hz    (dst_busy_hz)
    );

    assign dst_hz   = writes_ra && dst_busy_hz;
    assign in_ready = (!out_valid || out_ready) && !src1_hz && !src2_hz && !dst_hz && !flush;
    assign accept   = in_valid && in_ready;
    // A flushed writer will never reach writeback, so release its destination.
    assign kill_en  = flush && out_valid && out_wr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_opcode <= '0;
            out_dst    <= '0;
            out_wr     <= 1'b0;
            out_a      <= '0;
            out_b      <= '0;
            out_imm    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_opcode <= opcode;
            out_dst    <= ra;
            out_wr     <= writes_ra;
            out_a      <= opnd_a;
            out_b      <= opnd_b;
            out_imm    <= imm_ext;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a per-cycle behavioural model.
module tb_operand_fetch;
    import cpu_pkg::*;

    localparam logic [31:0] WR_MASK  = 32'h0000_00FF;
    localparam logic [31:0] SRC_MASK = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [3:0]  rf_sel1, rf_sel2;
    logic [31:0] rf_data1, rf_data2;
    logic        wb_en;
    logic [3:0]  wb_sel;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_opcode;
    logic [3:0]  out_dst;
    logic        out_wr;
    logic [31:0] out_a, out_b, out_imm;

    int checks   = 0;
    int failures = 0;
    bit go       = 1'b0;

    logic [31:0] rf [16];

    operand_fetch #(
        .WRITES_RA_MASK (WR_MASK),
        .RA_SRC_MASK    (SRC_MASK)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .rf_sel1(rf_sel1), .rf_sel2(rf_sel2),
        .rf_data1(rf_data1), .rf_data2(rf_data2), .wb_en(wb_en),
        .wb_sel(wb_sel), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_dst(out_dst), .out_wr(out_wr), .out_a(out_a), .out_b(out_b),
        .out_imm(out_imm)
    );

    always #5 clk = ~clk;

    assign rf_data1 = rf[rf_sel1];
    assign rf_data2 = rf[rf_sel2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input int ra, input int rb, input int rc);
        mk = {op, 4'(ra), 4'(rb), 4'(rc), 15'h0};
    endfunction

    function automatic logic [31:0] mki(input logic [4:0] op, input int ra, input int rb, input logic [18:0] c);
        mki = {op, 4'(ra), 4'(rb), c};
    endfunction

    // Model: an issue slot plus a set of registers awaiting writeback.
    logic [15:0] m_busy = '0;
    logic        m_ov = 1'b0, m_wr = 1'b0;
    logic [4:0]  m_op = '0;
    logic [3:0]  m_dst = '0;
    logic [31:0] m_a = '0, m_b = '0, m_imm = '0;

    function automatic logic [3:0] d_src1(input logic [31:0] ins);
        return ins[22:19];
    endfunction
    function automatic logic [3:0] d_src2(input logic [31:0] ins);
        return SRC_MASK[ins[31:27]] ? ins[26:23] : ins[18:15];
    endfunction
    function automatic logic pending(input logic [3:0] r);
        return m_busy[r] && !(wb_en && wb_sel == r);
    endfunction
    function automatic logic m_ready();
        logic [31:0] ins;
        ins = in_instr;
        return (!m_ov || out_ready) && !flush && !pending(d_src1(ins)) && !pending(d_src2(ins))
               && !(WR_MASK[ins[31:27]] && pending(ins[26:23]));
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = '0; m_ov = 0; m_wr = 0; m_op = '0; m_dst = '0;
            m_a = '0; m_b = '0; m_imm = '0;
        end else begin
            logic        acc;
            logic [3:0]  s1, s2;
            logic [15:0] nb;
            acc = in_valid && m_ready();
            s1  = d_src1(in_instr);
            s2  = d_src2(in_instr);
            nb  = m_busy;
            if (wb_en) nb[wb_sel] = 1'b0;
            if (flush && m_ov && m_wr) nb[m_dst] = 1'b0;
            if (acc) begin
                if (WR_MASK[in_instr[31:27]]) nb[in_instr[26:23]] = 1'b1;
                m_op  = in_instr[31:27];
                m_dst = in_instr[26:23];
                m_wr  = WR_MASK[in_instr[31:27]];
                m_a   = (wb_en && wb_sel == s1) ? wb_data : rf[s1];
                m_b   = (wb_en && wb_sel == s2) ? wb_data : rf[s2];
                m_imm = $signed(in_instr[18:0]);
                m_ov  = 1'b1;
            end else if (flush || out_ready) begin
                m_ov = 1'b0;
            end
            m_busy = nb;
        end
    end

    always @(posedge clk)
        if (wb_en) rf[wb_sel] <= wb_data;

    always @(negedge clk) begin
        if (go) begin
            chk("cmp_in_ready", 32'(in_ready), 32'(m_ready()));
            chk("cmp_sel1", 32'(rf_sel1), 32'(d_src1(in_instr)));
            chk("cmp_sel2", 32'(rf_sel2), 32'(d_src2(in_instr)));
            chk("cmp_out_valid", 32'(out_valid), 32'(m_ov));
            chk("cmp_opcode", 32'(out_opcode), 32'(m_op));
            chk("cmp_dst", 32'(out_dst), 32'(m_dst));
            chk("cmp_wr", 32'(out_wr), 32'(m_wr));
            chk("cmp_a", out_a, m_a);
            chk("cmp_b", out_b, m_b);
            chk("cmp_imm", out_imm, m_imm);
            chk("cmp_busy", 32'(dut.u_sb.busy), 32'(m_busy));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 32'(i * 256);
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        reset = 1'b1; in_valid = 0; in_instr = '0; wb_en = 0; wb_sel = '0;
        wb_data = '0; flush = 0; out_ready = 1'b1;
        tick(); tick();
        go = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_a", out_a, 32'd0);
        chk("rst_busy", 32'(dut.u_sb.busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        reset = 1'b0;

        // ADD R3,R1,R2
        in_valid = 1; in_instr = mk(OP_ADD, 3, 1, 2);
        #1 chk("add_ready", 32'(in_ready), 32'd1);
        tick();
        in_instr = mk(OP_ADD, 4, 3, 1);
        #1;
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_a", out_a, 32'd5);
        chk("add_b", out_b, 32'd7);
        chk("add_dst", 32'(out_dst), 32'd3);
        chk("add_wr", 32'(out_wr), 32'd1);
        chk("add_busy3", 32'(dut.u_sb.busy[3]), 32'd1);
        chk("raw_stall", 32'(in_ready), 32'd0);
        tick();
        wb_en = 1; wb_sel = 4'd3; wb_data = 32'h0C;
        #1 chk("raw_wb_ready", 32'(in_ready), 32'd1);
        tick();
        wb_en = 0; in_valid = 0;
        #1;
        chk("fwd_a", out_a, 32'h0C);
        chk("fwd_b", out_b, 32'd5);
        chk("fwd_busy", 32'(dut.u_sb.busy), 32'h0010);

        // Output hold with a pending second instruction
        out_ready = 0; in_valid = 1; in_instr = mk(OP_SUB, 7, 1, 2);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_ready", 32'(in_ready), 32'd0);
            chk("hold_a", out_a, 32'h0C);
            chk("hold_dst", 32'(out_dst), 32'd4);
            tick();
        end
        out_ready = 1;
        #1 chk("release_ready", 32'(in_ready), 32'd1);
        tick();
        in_instr = mki(OP_LD, 8, 1, 19'h40000);
        #1;
        chk("second_dst", 32'(out_dst), 32'd7);
        chk("second_op", 32'(out_opcode), 32'(OP_SUB));
        chk("second_b", out_b, 32'd7);

        // Immediate sign extension
        tick();
        in_instr = mki(OP_ST, 1, 2, 19'h0007F);
        #1;
        chk("imm_neg", out_imm, 32'hFFFC0000);
        chk("st_sel2", 32'(rf_sel2), 32'd1);
        tick();
        #1;
        chk("imm_pos", out_imm, 32'h0000007F);
        chk("st_b", out_b, 32'd5);
        chk("st_wr", 32'(out_wr), 32'd0);

        // Flush of a stalled writer
        in_instr = mk(OP_ADD, 5, 1, 2);
        tick();
        in_valid = 0; out_ready = 0;
        #1;
        chk("fl_busy5_set", 32'(dut.u_sb.busy[5]), 32'd1);
        tick();
        flush = 1;
        #1 chk("fl_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 0;
        #1;
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_busy5", 32'(dut.u_sb.busy[5]), 32'd0);
        out_ready = 1; in_valid = 1; in_instr = mk(OP_ADD, 9, 5, 1);
        #1 chk("fl_reader_ready", 32'(in_ready), 32'd1);
        tick();
        #1 chk("fl_reader_a", out_a, 32'h500);

        // Back-to-back writers of R6
        in_instr = mk(OP_ADD, 6, 1, 2);
        tick();
        in_instr = mk(OP_ADD, 6, 2, 1);
        #1 chk("waw_stall", 32'(in_ready), 32'd0);
        tick();
        wb_en = 1; wb_sel = 4'd6; wb_data = 32'h66;
        #1 chk("waw_ready", 32'(in_ready), 32'd1);
        tick();
        wb_en = 0; out_ready = 0; in_instr = mk(OP_ADD, 10, 1, 2);
        #1;
        chk("waw_busy6", 32'(dut.u_sb.busy[6]), 32'd1);
        chk("waw_a", out_a, 32'd7);
        tick();
        reset = 1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(dut.u_sb.busy), 32'd0);
        tick();
        reset = 0; in_valid = 0; out_ready = 1;
        tick(); tick();
        go = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
